// File: rtl/deserializer_unit_cell_16.sv
// Serial-to-parallel receive cell: aligns to SYNC, assembles DATA_W bits LSB first,
// skips gap slots and free-runs frame after frame once locked.
//
// state | meaning
// IDLE  | unaligned, waiting for the first SYNC
// SHIFT | data slots, CNT 0..DATA_W-1
// GAP   | gap slots, CNT DATA_W..FRAME_LEN-1
module deserializer_unit_cell_16 #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SERIAL_IN,
  input  logic              SYNC,
  output logic [DATA_W-1:0] PAR_OUT,
  output logic              PAR_VALID,
  output logic              LOCKED,
  output logic              SYNC_ERR
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FIRST_GAP = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);
  localparam bit               HAS_GAP   = (FRAME_LEN > DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift_q;

  always_ff @(posedge CLK) begin
    PAR_VALID <= 1'b0;
    SYNC_ERR  <= 1'b0;
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= '0;
      PAR_OUT <= '0;
      LOCKED  <= 1'b0;
    end else if (SYNC) begin
      // SYNC always realigns; only the expected bit-0 slot is silent
      shift_q  <= {SERIAL_IN, {(DATA_W-1){1'b0}}};
      cnt      <= CNT_W'(1);
      state    <= SHIFT;
      LOCKED   <= 1'b1;
      SYNC_ERR <= (state == GAP) || ((state == SHIFT) && (cnt != '0));
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        SHIFT: begin
          shift_q <= {SERIAL_IN, shift_q[DATA_W-1:1]};
          if (cnt == LAST_DATA) begin
            PAR_OUT   <= {SERIAL_IN, shift_q[DATA_W-1:1]};
            PAR_VALID <= 1'b1;
            if (HAS_GAP) begin
              state <= GAP;
              cnt   <= FIRST_GAP;
            end else begin
              cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == LAST_SLOT) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_unit_cell_16.sv
// Bench for deserializer_unit_cell_16: slot-position reference model compared every
// cycle, directed frame scenarios with literal expectations, then random stimulus.
module tb_deserializer_unit_cell_16;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 32;

  logic              CLK = 1'b0;
  logic              RESET, SERIAL_IN, SYNC;
  logic [DATA_W-1:0] PAR_OUT;
  logic              PAR_VALID, LOCKED, SYNC_ERR;

  deserializer_unit_cell_16 #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .SYNC(SYNC),
    .PAR_OUT(PAR_OUT), .PAR_VALID(PAR_VALID), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: position of the current slot within the frame
  bit              m_locked = 0;
  int              m_pos    = 0;
  logic [DATA_W-1:0] m_bits = '0;
  logic [DATA_W-1:0] m_out  = '0;
  bit              m_valid  = 0;
  bit              m_err    = 0;

  always @(posedge CLK) begin
    m_valid = 0;
    m_err   = 0;
    if (RESET) begin
      m_locked = 0;
      m_pos    = 0;
      m_out    = '0;
    end else if (SYNC) begin
      m_err     = m_locked && (m_pos != 0);
      m_locked  = 1;
      m_bits[0] = SERIAL_IN;
      m_pos     = 1;
    end else if (m_locked) begin
      if (m_pos < DATA_W) begin
        m_bits[m_pos] = SERIAL_IN;
        if (m_pos == DATA_W - 1) begin
          m_valid = 1;
          m_out   = m_bits;
        end
      end
      m_pos = (m_pos + 1) % FRAME_LEN;
    end
  end

  bit chk_en = 0;
  int cycle  = 0;
  int vcount = 0;
  int ecount = 0;
  int vcyc[$];

  always @(negedge CLK) begin
    cycle++;
    if (chk_en) begin
      chk("par_out", 32'(PAR_OUT), 32'(m_out));
      chk("par_valid", 32'(PAR_VALID), 32'(m_valid));
      chk("locked", 32'(LOCKED), 32'(m_locked));
      chk("sync_err", 32'(SYNC_ERR), 32'(m_err));
      if (PAR_VALID === 1'b1) begin
        vcount++;
        vcyc.push_back(cycle);
      end
      if (SYNC_ERR === 1'b1) ecount++;
    end
  end

  task automatic cyc(input logic r, input logic s, input logic d);
    RESET = r; SYNC = s; SERIAL_IN = d;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Drive slots start..start+n-1 of a frame carrying word w; gap slots get random bits
  task automatic send(input logic [DATA_W-1:0] w, input int start, input int n,
                      input logic sync_first);
    for (int i = 0; i < n; i++) begin
      int slot;
      slot = start + i;
      cyc(1'b0, sync_first && (i == 0), (slot < DATA_W) ? w[slot] : 1'($urandom));
    end
  endtask

  logic [DATA_W-1:0] words2 [4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};

  initial begin
    int v0, e0, q0;
    RESET = 1'b1; SYNC = 1'b0; SERIAL_IN = 1'b0;
    @(negedge CLK);
    cyc(1'b1, 1'b0, 1'b0);
    chk_en = 1;
    chk("rst_valid", 32'(PAR_VALID), 32'd0);
    chk("rst_locked", 32'(LOCKED), 32'd0);
    chk("rst_out", 32'(PAR_OUT), 32'd0);

    // 1: single frame 0xA5C3
    send(16'hA5C3, 0, DATA_W, 1'b1);
    chk("t1_valid", 32'(PAR_VALID), 32'd1);
    chk("t1_out", 32'(PAR_OUT), 32'h0000A5C3);
    chk("t1_locked", 32'(LOCKED), 32'd1);
    for (int i = 0; i < FRAME_LEN - DATA_W; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("t1_one_pulse", 32'(vcount), 32'd1);

    // 2: four free-running frames after one SYNC
    v0 = vcount; q0 = vcyc.size();
    for (int f = 0; f < 4; f++) send(words2[f], 0, FRAME_LEN, f == 0);
    chk("t2_pulses", 32'(vcount - v0), 32'd4);
    for (int f = 1; f < 4; f++) chk("t2_spacing", 32'(vcyc[q0+f] - vcyc[q0+f-1]), 32'd32);
    chk("t2_last", 32'(PAR_OUT), 32'h00001234);

    // 3: SYNC at every expected bit-0 slot
    e0 = ecount;
    send(16'h0F0F, 0, FRAME_LEN, 1'b1);
    send(16'hF00D, 0, FRAME_LEN, 1'b1);
    send(16'h6A6A, 0, FRAME_LEN, 1'b1);
    chk("t3_no_err", 32'(ecount - e0), 32'd0);
    chk("t3_out", 32'(PAR_OUT), 32'h00006A6A);

    // 4a: SYNC at data slot 7
    send(16'h1111, 0, 7, 1'b1);
    v0 = vcount;
    send(16'hBEEF, 0, 1, 1'b1);
    chk("t4_err7", 32'(SYNC_ERR), 32'd1);
    send(16'hBEEF, 1, DATA_W - 2, 1'b0);
    chk("t4_no_partial", 32'(vcount - v0), 32'd0);
    send(16'hBEEF, DATA_W - 1, FRAME_LEN - DATA_W + 1, 1'b0);
    chk("t4_word", 32'(PAR_OUT), 32'h0000BEEF);
    chk("t4_one", 32'(vcount - v0), 32'd1);
    // 4b: SYNC at slot 15 suppresses that word
    send(16'h7777, 0, DATA_W - 1, 1'b0);
    send(16'hC0DE, 0, 1, 1'b1);
    chk("t4_err15", 32'(SYNC_ERR), 32'd1);
    chk("t4_sup_valid", 32'(PAR_VALID), 32'd0);
    chk("t4_sup_hold", 32'(PAR_OUT), 32'h0000BEEF);
    send(16'hC0DE, 1, FRAME_LEN - 1, 1'b0);
    chk("t4_realign", 32'(PAR_OUT), 32'h0000C0DE);

    // 5: SYNC at gap slot 20
    send(16'h3C3C, 0, 20, 1'b0);
    send(16'h9999, 0, 1, 1'b1);
    chk("t5_err", 32'(SYNC_ERR), 32'd1);
    send(16'h9999, 1, FRAME_LEN - 1, 1'b0);
    chk("t5_word", 32'(PAR_OUT), 32'h00009999);

    // 6: reset mid-frame, then no SYNC, then SYNC with RESET
    send(16'h4321, 0, 10, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t6_out", 32'(PAR_OUT), 32'd0);
    chk("t6_locked", 32'(LOCKED), 32'd0);
    chk("t6_valid", 32'(PAR_VALID), 32'd0);
    v0 = vcount;
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'($urandom));
    chk("t6_no_valid", 32'(vcount - v0), 32'd0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t6_sync_rst", 32'(LOCKED), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t6_idle", 32'(LOCKED), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, 1'($urandom));

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
